// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad, debounces press and release,
// and emits one-cycle key events plus a 16-bit key value for the I/O unit.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   row_in    raw keypad rows (active-low, asynchronous to clk)
//   col_out   column drive, exactly one bit low
//   clr       synchronous clear of kdata (wins over a simultaneous accept)
//   kdata     accumulated key value
//   key_code  last accepted key, row*4 + col
//   key_valid one-cycle pulse per accepted press
// Build option: define KEYPAD_ACCUM_EN to shift each new digit into kdata
// (4-digit hex entry); otherwise kdata holds only the last key.
module keypad_scan #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    input  logic        clr,
    output logic [15:0] kdata,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_rs1, r_rs;
    logic [1:0]     r_col, w_col_nxt, r_row, w_row_nxt, w_row_pri;
    logic [SW-1:0]  r_dwell, w_dwell_nxt;
    logic [DW-1:0]  r_deb, w_deb_nxt;
    logic           w_accept, w_all_hi;
    logic [3:0]     w_code;
    logic [15:0]    w_kdata_acc;
    logic [3:0]     r_col_out;
    logic [15:0]    r_kdata;
    logic [3:0]     r_key_code;
    logic           r_key_valid;

    assign w_all_hi  = &r_rs;
    // lowest-index low row wins when several rows are pressed
    assign w_row_pri = !r_rs[0] ? 2'd0 : !r_rs[1] ? 2'd1 : !r_rs[2] ? 2'd2 : 2'd3;
    assign w_code    = {r_row, r_col};

`ifdef KEYPAD_ACCUM_EN
    assign w_kdata_acc = {r_kdata[11:0], w_code};
`else
    assign w_kdata_acc = {12'h000, w_code};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_dwell_nxt = r_dwell;
        w_deb_nxt   = r_deb;
        w_accept    = 1'b0;
        case (r_state)
            SCAN: begin
                if (r_dwell == SCAN_LAST) begin
                    w_dwell_nxt = '0;
                    if (!w_all_hi) begin
                        w_row_nxt   = w_row_pri;
                        w_deb_nxt   = '0;
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_col_nxt = r_col + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (r_rs[r_row]) begin
                    w_dwell_nxt = '0;
                    w_state_nxt = SCAN;
                end else if (r_deb == DEB_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_deb_nxt = r_deb + DW'(1);
                end
            end
            HELD: begin
                if (w_all_hi) begin
                    w_deb_nxt   = '0;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_all_hi) begin
                    w_deb_nxt = '0;
                end else if (r_deb == DEB_LAST) begin
                    w_col_nxt   = r_col + 2'd1;
                    w_dwell_nxt = '0;
                    w_state_nxt = SCAN;
                end else begin
                    w_deb_nxt = r_deb + DW'(1);
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1   <= 4'hF;
            r_rs    <= 4'hF;
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_dwell <= '0;
            r_deb   <= '0;
        end else begin
            r_rs1   <= row_in;
            r_rs    <= r_rs1;
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_dwell <= w_dwell_nxt;
            r_deb   <= w_deb_nxt;
        end
    end

    // column drive is registered from the next column so it tracks r_col exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_out   <= 4'b1110;
            r_kdata     <= 16'h0000;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
        end else begin
            r_col_out   <= ~(4'b0001 << w_col_nxt);
            r_kdata     <= clr ? 16'h0000 : w_accept ? w_kdata_acc : r_kdata;
            r_key_code  <= w_accept ? w_code : r_key_code;
            r_key_valid <= w_accept;
        end
    end

    assign col_out   = r_col_out;
    assign kdata     = r_kdata;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
endmodule

// File: doc/keypad_scan.md
# keypad_scan

- Upstream input stage for the CPU's memory-mapped I/O path.
- Scans a 4x4 active-low matrix keypad, debounces each press and release, and emits one-cycle key events.
- Keeps a 16-bit value register that drives the I/O unit's 16-bit keyboard data input, which the CPU reads as the upper half of an I/O load.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled (≥2).
- DEB_CYCLES, 200000: consecutive stable cycles needed to accept a press or a release (≥2).

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- row_in  input  4  raw keypad rows; active-low, pulled up externally, asynchronous to clk.
- col_out  output  4  column drive; exactly one bit low at all times.
- clr  input  1  synchronous clear of kdata, level-sampled on each clk edge.
- kdata  output  16  accumulated key value delivered to the I/O unit.
- key_code  output  4  code of the last accepted key, = row*4 + col.
- key_valid  output  1  one-cycle pulse when a press is accepted.

## Operation
- row_in passes through a 2-flop synchronizer (reset 4'hF). All logic uses the synchronized value rs.
- Row priority: when several rows are low, the lowest index wins.
- Column index col (0..3) drives col_out = ~(4'b1 << col).
- States are SCAN, DEBOUNCE, HELD and RELEASE.
- SCAN
  - Dwell counter runs 0..SCAN_DIV-1 with column col driven.
  - At the last dwell cycle, if any rs bit is low: latch col and row, clear the debounce counter, go to DEBOUNCE.
  - Otherwise advance col, wrapping 3→0, and restart the dwell.
- DEBOUNCE
  - col is held.
  - Each cycle the latched row bit of rs is low, increment the counter.
  - If that bit is high, return to SCAN with the same col and the dwell restarted.
  - When the counter reaches DEB_CYCLES-1 the key is accepted:
    - pulse key_valid;
    - set key_code;
    - update kdata (see Configuration);
    - go to HELD.
- HELD: stay until all rs bits are high, then clear the counter and go to RELEASE.
- RELEASE
  - Count consecutive all-high cycles. Any low bit clears the counter and keeps the state.
  - At DEB_CYCLES-1, go to SCAN, advance col and restart the dwell.
- clr
  - Sets kdata to 0 in any state.
  - If clr and an accept occur in the same cycle, clr wins for kdata. key_valid and key_code still update.
- Other keys pressed in HELD or RELEASE are ignored. No rollover.

## Timing
- Reset values:
  - col_out = 4'b1110 (col 0);
  - kdata = 16'h0000;
  - key_code = 4'h0;
  - key_valid = 0;
  - state SCAN; dwell and debounce counters 0.
- rst_n low mid-press forces the reset values immediately, with no event emitted. Scanning restarts at col 0.
- All outputs are registered.
- Press latency:
  - a key stable from a given cycle is seen in rs 2 cycles later;
  - worst-case detection takes 4*SCAN_DIV cycles;
  - key_valid asserts DEB_CYCLES cycles after entering DEBOUNCE.
- kdata and key_code change on the same edge that raises key_valid. key_valid is high for exactly one cycle per press.
- Minimum interval between two events is 2*DEB_CYCLES cycles.
- A bounce shorter than DEB_CYCLES cycles never produces an event.

## Configuration
- KEYPAD_ACCUM_EN defined: on accept, kdata <= {kdata[11:0], code}. This forms a 4-digit hex entry; older digits shift out of the top.
- KEYPAD_ACCUM_EN undefined: on accept, kdata <= {12'h000, code}, i.e. the last key only.
- clr behaves identically in both builds.

## Test plan
All tests use SCAN_DIV=4 and DEB_CYCLES=8.
- Reset: hold rst_n low, then release → kdata=0000, key_valid=0, col_out=1110. col_out rotates through 1101, 1011, 0111, 1110 every 4 cycles.
- Clean press of row 1 / col 2 → exactly one key_valid pulse with key_code=4'h6. With ACCUM, kdata goes from 0000 to 0006.
- Bounce: press, toggle row low/high every 3 cycles for 30 cycles, then release → no key_valid.
- Accumulate (ACCUM): keys 1, 2, A, F, 3 → kdata ends at 2AF3. Without ACCUM → kdata=0003.
- clr high in the same cycle as an accept of key 5 → kdata=0000, key_valid=1, key_code=5. A following key 7 gives kdata=0007.
- Drop rst_n during DEBOUNCE, and separately during HELD → outputs return to reset values with no pulse. Holding the key after reset gives exactly one event.
